// File: rtl/lifo_reverser_pkg.sv
// Shared types and constants for the LIFO packet reverser.
package lifo_pkg;

  localparam int DATA_W        = 8;
  localparam int DEPTH_DEFAULT = 7;

  typedef enum logic [2:0] {
    FILL,
    TURN,
    POP,
    CAPT,
    SEND
  } state_t;

endpackage

// File: rtl/lifo_reverser_if.sv
// Byte stream with valid/ready handshake and end-of-packet marker.
interface lifo_reverser_if;
  import lifo_pkg::*;

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/lifo_reverser.sv
// Packet byte reverser: pushes the input stream into an external LIFO, then
// pops it back out in reverse order, closing segments at DEPTH bytes.
module lifo_reverser
  import lifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int CW    = 3
) (
  input  logic              clock,
  input  logic              reset,
  lifo_reverser_if.slave    in_s,
  lifo_reverser_if.master   out_s,
  output logic              seg_split,
  output logic              lifo_wn,
  output logic              lifo_rn,
  output logic [DATA_W-1:0] lifo_din,
  input  logic [DATA_W-1:0] lifo_dout,
  input  logic              lifo_full
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q;
  logic [DATA_W-1:0] data_q;
  logic              last_q;
  logic              split_q;
  logic              push;
  logic              in_ready;

  // Strobes are gated with reset so nothing reaches the stack during the reset cycle.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    lifo_rn  = 1'b0;
    push     = 1'b0;
    unique case (state_q)
      FILL: begin
        in_ready = reset && (count_q < DEPTH_C) && !lifo_full;
        push     = in_s.valid && in_ready;
        if (push && (in_s.last || (count_q == DEPTH_C - ONE_C)))
          state_d = TURN;
      end
      TURN: state_d = POP;
      POP: begin
        lifo_rn = reset;
        state_d = CAPT;
      end
      CAPT: state_d = SEND;
      SEND: begin
        if (out_s.ready)
          state_d = last_q ? FILL : POP;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= FILL;
      count_q <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      split_q <= 1'b0;
    end else begin
      state_q <= state_d;
      split_q <= push && !in_s.last && (count_q == DEPTH_C - ONE_C);
      if (push)
        count_q <= count_q + ONE_C;
      else if (state_q == POP)
        count_q <= count_q - ONE_C;
      if (state_q == CAPT) begin
        data_q <= lifo_dout;
        last_q <= (count_q == '0);
      end
    end
  end

  assign in_s.ready  = in_ready;
  assign lifo_wn     = push;
  assign lifo_din    = in_s.data;
  assign seg_split   = split_q;
  assign out_s.valid = (state_q == SEND);
  assign out_s.data  = data_q;
  assign out_s.last  = last_q;

endmodule

// File: tb/tb_lifo_reverser.sv
// Self-checking bench for lifo_reverser with a behavioural LIFO stack model.
module tb_lifo_reverser;
  import lifo_pkg::*;

  localparam int DEPTH = 7;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       seg_split, lifo_wn, lifo_rn, lifo_full;
  logic [7:0] lifo_din;
  logic [7:0] lifo_dout;
  logic       rdy_rand = 1'b0;

  always #5 clock = ~clock;

  lifo_reverser_if in_if ();
  lifo_reverser_if out_if ();

  lifo_reverser #(.DEPTH(DEPTH), .CW(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_s      (in_if.slave),
    .out_s     (out_if.master),
    .seg_split (seg_split),
    .lifo_wn   (lifo_wn),
    .lifo_rn   (lifo_rn),
    .lifo_din  (lifo_din),
    .lifo_dout (lifo_dout),
    .lifo_full (lifo_full)
  );

  // Stack model; its active-high reset is the inverted block reset.
  logic [7:0] stk [0:DEPTH-1];
  int         sp = 0;
  wire        stack_rst = !reset;
  always @(posedge clock) begin
    if (stack_rst) begin
      sp        <= 0;
      lifo_dout <= '0;
    end else begin
      if (lifo_wn && sp < DEPTH) begin
        stk[sp] <= lifo_din;
        sp      <= sp + 1;
      end
      if (lifo_rn && sp > 0) begin
        lifo_dout <= stk[sp-1];
        sp        <= sp - 1;
      end
    end
  end
  assign lifo_full = (sp >= DEPTH);

  // Monitor: handshakes and strobes are sampled mid-cycle.
  logic [8:0] got   [0:4095];
  time        got_t [0:4095];
  int         got_n = 0;
  int         n_wn = 0, n_rn = 0, n_split = 0, n_both = 0, n_viol = 0;
  logic       pv = 1'b0, pr = 1'b0;
  logic [8:0] pd = '0;
  always @(negedge clock) begin
    if (!reset) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr && (!out_if.valid || {out_if.last, out_if.data} != pd)) n_viol++;
      if (out_if.valid && out_if.ready && got_n < 4096) begin
        got[got_n]   = {out_if.last, out_if.data};
        got_t[got_n] = $time;
        got_n++;
      end
      if (lifo_wn) n_wn++;
      if (lifo_rn) n_rn++;
      if (seg_split) n_split++;
      if (lifo_wn && lifo_rn) n_both++;
      pv = out_if.valid;
      pr = out_if.ready;
      pd = {out_if.last, out_if.data};
    end
  end

  int checks = 0, failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (rdy_rand) out_if.ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic push_byte(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    in_if.valid = 1'b1;
    in_if.data  = d;
    in_if.last  = l;
    while (!in_if.ready && n < 300) begin
      tick();
      n++;
    end
    if (!in_if.ready) tmo("push_wait");
    tick();
    in_if.valid = 1'b0;
    in_if.last  = 1'b0;
  endtask

  task automatic wait_out(input int target, input string name);
    int n;
    n = 0;
    while (got_n < target && n < 3000) begin
      tick();
      n++;
    end
    if (got_n < target) tmo(name);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!out_if.valid && n < 50) begin
      tick();
      n++;
    end
    if (!out_if.valid) tmo(name);
  endtask

  typedef struct {
    int               len;
    logic [15:0][7:0] pkt;
    int               olen;
    logic [15:0][8:0] exp;
    int               splits;
  } vec_t;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vt [5];
    int         base, w0, r0, s0, n;
    logic [7:0] b [0:31];
    logic [8:0] expq [$];
    int         tot_len, tot_split, len;

    // Expected entries are {last, data}; element 0 is the first byte.
    vt[0].len = 3; vt[0].pkt = 128'({8'h33, 8'h22, 8'h11});
    vt[0].olen = 3; vt[0].exp = 144'({9'h111, 9'h022, 9'h033}); vt[0].splits = 0;
    vt[1].len = 1; vt[1].pkt = 128'({8'hA5});
    vt[1].olen = 1; vt[1].exp = 144'({9'h1A5}); vt[1].splits = 0;
    vt[2].len = 9;
    vt[2].pkt = 128'({8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01});
    vt[2].olen = 9;
    vt[2].exp = 144'({9'h108, 9'h009, 9'h101, 9'h002, 9'h003, 9'h004, 9'h005, 9'h006, 9'h007});
    vt[2].splits = 1;
    vt[3].len = 7;
    vt[3].pkt = 128'({8'h46, 8'h45, 8'h44, 8'h43, 8'h42, 8'h41, 8'h40});
    vt[3].olen = 7;
    vt[3].exp = 144'({9'h140, 9'h041, 9'h042, 9'h043, 9'h044, 9'h045, 9'h046});
    vt[3].splits = 0;
    vt[4].len = 8;
    vt[4].pkt = 128'({8'h57, 8'h56, 8'h55, 8'h54, 8'h53, 8'h52, 8'h51, 8'h50});
    vt[4].olen = 8;
    vt[4].exp = 144'({9'h157, 9'h150, 9'h051, 9'h052, 9'h053, 9'h054, 9'h055, 9'h056});
    vt[4].splits = 1;

    in_if.valid = 1'b0; in_if.data = '0; in_if.last = 1'b0;
    out_if.ready = 1'b0;

    // Reset held two edges with an input offered.
    tick();
    in_if.valid = 1'b1; in_if.data = 8'hEE;
    tick();
    @(negedge clock);
    chk("rst_in_ready", int'(in_if.ready), 0);
    chk("rst_out_valid", int'(out_if.valid), 0);
    chk("rst_out_data", int'(out_if.data), 0);
    chk("rst_out_last", int'(out_if.last), 0);
    chk("rst_seg_split", int'(seg_split), 0);
    chk("rst_lifo_wn", int'(lifo_wn), 0);
    chk("rst_lifo_rn", int'(lifo_rn), 0);
    tick();
    in_if.valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    chk("post_rst_in_ready", int'(in_if.ready), 1);
    out_if.ready = 1'b1;

    // Latency and drain rate on 0x11,0x22,0x33.
    base = got_n;
    push_byte(8'h11, 1'b0);
    push_byte(8'h22, 1'b0);
    push_byte(8'h33, 1'b1);
    n = 1;
    while (!out_if.valid && n < 20) begin
      tick();
      n++;
    end
    chk("first_out_latency", n, 4);
    wait_out(base + 3, "lat_drain");
    chk("lat_byte0", int'(got[base]), 'h033);
    chk("lat_byte1", int'(got[base+1]), 'h022);
    chk("lat_byte2", int'(got[base+2]), 'h111);
    chk("drain_gap0", int'(got_t[base+1] - got_t[base]), 30);
    chk("drain_gap1", int'(got_t[base+2] - got_t[base+1]), 30);

    // Table vectors.
    for (int v = 0; v < 5; v++) begin
      base = got_n; w0 = n_wn; r0 = n_rn; s0 = n_split;
      for (int i = 0; i < vt[v].len; i++)
        push_byte(vt[v].pkt[i], (i == vt[v].len - 1));
      wait_out(base + vt[v].olen, "vec_drain");
      chk($sformatf("vec%0d_in_ready_after", v), int'(in_if.ready), 1);
      for (int i = 0; i < vt[v].olen; i++)
        chk($sformatf("vec%0d_out%0d", v, i), int'(got[base+i]), int'(vt[v].exp[i]));
      repeat (6) tick();
      chk($sformatf("vec%0d_out_count", v), got_n - base, vt[v].olen);
      chk($sformatf("vec%0d_wn", v), n_wn - w0, vt[v].len);
      chk($sformatf("vec%0d_rn", v), n_rn - r0, vt[v].len);
      chk($sformatf("vec%0d_split", v), n_split - s0, vt[v].splits);
    end

    // Backpressure mid-drain.
    base = got_n;
    for (int i = 0; i < 4; i++) push_byte(8'hB0 + 8'(i), (i == 3));
    wait_out(base + 1, "bp_first");
    out_if.ready = 1'b0;
    r0 = n_rn;
    wait_valid("bp_valid");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", int'(out_if.valid), 1);
      chk("bp_hold_word", int'({out_if.last, out_if.data}), 'h0B2);
    end
    chk("bp_pops_stalled", n_rn - r0, 1);
    out_if.ready = 1'b1;
    wait_out(base + 4, "bp_drain");
    chk("bp_out0", int'(got[base]), 'h0B3);
    chk("bp_out1", int'(got[base+1]), 'h0B2);
    chk("bp_out2", int'(got[base+2]), 'h0B1);
    chk("bp_out3", int'(got[base+3]), 'h1B0);

    // Reset while in SEND with two bytes still stacked.
    base = got_n;
    for (int i = 0; i < 4; i++) push_byte(8'hD0 + 8'(i), (i == 3));
    wait_out(base + 1, "rs_first");
    out_if.ready = 1'b0;
    wait_valid("rs_valid");
    chk("rs_send_word", int'({out_if.last, out_if.data}), 'h0D2);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rs_valid_cleared", int'(out_if.valid), 0);
    out_if.ready = 1'b1;
    repeat (10) tick();
    chk("rs_aborted_silent", got_n - base, 1);
    push_byte(8'hC0, 1'b0);
    push_byte(8'hC1, 1'b1);
    wait_out(base + 3, "rs_next");
    chk("rs_next0", int'(got[base+1]), 'h0C1);
    chk("rs_next1", int'(got[base+2]), 'h1C0);
    repeat (10) tick();
    chk("rs_next_count", got_n - base, 3);

    // Random packets with random output backpressure against a segment model.
    base = got_n; w0 = n_wn; r0 = n_rn; s0 = n_split;
    tot_len = 0; tot_split = 0;
    rdy_rand = 1'b1;
    for (int p = 0; p < 25; p++) begin
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) b[i] = 8'($urandom);
      for (int s = 0; s < len; s += DEPTH) begin
        int e;
        e = (s + DEPTH < len) ? s + DEPTH - 1 : len - 1;
        for (int i = e; i >= s; i--) expq.push_back({(i == s), b[i]});
      end
      tot_len += len;
      tot_split += (len - 1) / DEPTH;
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 4) == 0) tick();
        push_byte(b[i], (i == len - 1));
      end
    end
    wait_out(base + expq.size(), "rand_drain");
    rdy_rand = 1'b0;
    out_if.ready = 1'b1;
    repeat (10) tick();
    chk("rand_out_count", got_n - base, expq.size());
    for (int i = 0; i < expq.size(); i++)
      chk($sformatf("rand_out%0d", i), int'(got[base+i]), int'(expq[i]));
    chk("rand_wn", n_wn - w0, tot_len);
    chk("rand_rn", n_rn - r0, tot_len);
    chk("rand_split", n_split - s0, tot_split);

    chk("wn_rn_overlap", n_both, 0);
    chk("valid_hold_violations", n_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
